// File: rtl/key_expansion_round_gen.sv
// ---------------------------------------------------------------------------
// key_expansion_round_gen
//   Sequential AES-128 key schedule. Takes a 128-bit cipher key on i_start and
//   streams round keys 0..10 over a valid/ready handshake, one per transfer.
//   SubWord uses four combinational byte_substitution_algorithm instances.
//
// Ports
//   i_clock      clock, all state updates on posedge
//   i_reset      asynchronous active-high reset
//   i_start      start request, sampled only while o_ready=1
//   i_key        cipher key, [127:120] is key byte 0 (MSB of w0)
//   o_ready      idle, able to accept i_start
//   o_round_key  current round key, same byte order as i_key
//   o_round_idx  round index of o_round_key (0..10)
//   o_valid      o_round_key / o_round_idx valid
//   i_ready      consumer accepts; transfer = o_valid & i_ready
//   o_done       1-cycle pulse on the cycle after round 10 is transferred
//   i_rd_idx     (KEY_EXPANSION_ROUND_STORE_EN only) stored key read index
//   o_rd_key     (KEY_EXPANSION_ROUND_STORE_EN only) stored key, 0 if absent
//
// Configuration macro: KEY_EXPANSION_ROUND_STORE_EN adds an 11-entry round key
// store with a combinational read port.
// ---------------------------------------------------------------------------

// AES forward S-box; optional output register for pipelined users.
module byte_substitution_algorithm #(
  parameter int CREATE_OUTPUT_REG = 0
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  // Entry x lives at bits [(255-x)*8 +: 8], i.e. entry 0 is the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] sub_s;

  // (255-x)*8 is simply {~x, 3'b000}
  assign sub_s = SBOX_TABLE[{~i_byte, 3'b000} +: 8];

  generate
    if (CREATE_OUTPUT_REG != 0) begin : g_reg
      logic [7:0] byte_r;
      // Register the substituted byte
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          byte_r <= 8'h00;
        end else begin
          byte_r <= sub_s;
        end
      end
      assign o_byte = byte_r;
    end else begin : g_comb
      logic unused_s;
      assign unused_s = i_clock ^ i_reset;
      assign o_byte   = sub_s;
    end
  endgenerate
endmodule

module key_expansion_round_gen #(
  parameter int NB_BYTE  = 8,
  parameter int NB_KEY   = 128,
  parameter int N_ROUNDS = 10
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [NB_KEY-1:0] i_key,
  output logic              o_ready,
  output logic [NB_KEY-1:0] o_round_key,
  output logic [3:0]        o_round_idx,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_done
`ifdef KEY_EXPANSION_ROUND_STORE_EN
  ,
  input  logic [3:0]        i_rd_idx,
  output logic [NB_KEY-1:0] o_rd_key
`endif
);
  generate
    if (NB_BYTE != 8 || NB_KEY != 128 || N_ROUNDS != 10) begin : g_bad_conf
      $error("BAD_CONF: only NB_BYTE=8, NB_KEY=128, N_ROUNDS=10 are supported");
    end
  endgenerate

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'd10;

  // GF(2^8) multiply-by-2, advances rcon to the next round constant
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [0:0]        state_r;
  logic              ready_r;
  logic              valid_r;
  logic              done_r;
  logic [NB_KEY-1:0] key_r;
  logic [3:0]        idx_r;
  logic [7:0]        rcon_r;

  logic              transfer_s;
  logic              accept_s;
  logic [31:0]       w0_s, w1_s, w2_s, w3_s;
  logic [31:0]       rot_s, sub_s, t_s;
  logic [31:0]       n0_s, n1_s, n2_s, n3_s;

  assign transfer_s = valid_r & i_ready;
  assign accept_s   = (state_r == ST_IDLE) & i_start;

  // Next round key from the current one
  assign {w0_s, w1_s, w2_s, w3_s} = key_r;
  assign rot_s = {w3_s[23:0], w3_s[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      byte_substitution_algorithm #(
        .CREATE_OUTPUT_REG (0)
      ) u_sbox (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_byte  (rot_s[gi*8 +: 8]),
        .o_byte  (sub_s[gi*8 +: 8])
      );
    end
  endgenerate

  assign t_s  = sub_s ^ {rcon_r, 24'h000000};
  assign n0_s = w0_s ^ t_s;
  assign n1_s = w1_s ^ n0_s;
  assign n2_s = w2_s ^ n1_s;
  assign n3_s = w3_s ^ n2_s;

  // Control FSM plus round key / index / rcon state
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      key_r   <= {NB_KEY{1'b0}};
      idx_r   <= 4'd0;
      rcon_r  <= 8'h01;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            state_r <= ST_RUN;
            ready_r <= 1'b0;
            valid_r <= 1'b1;
            key_r   <= i_key;
            idx_r   <= 4'd0;
            rcon_r  <= 8'h01;
          end
        end
        ST_RUN: begin
          // Without a transfer everything holds (backpressure)
          if (transfer_s) begin
            if (idx_r == LAST_IDX) begin
              state_r <= ST_IDLE;
              ready_r <= 1'b1;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              key_r  <= {n0_s, n1_s, n2_s, n3_s};
              idx_r  <= idx_r + 4'd1;
              rcon_r <= xtime(rcon_r);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = ready_r;
  assign o_valid     = valid_r;
  assign o_done      = done_r;
  assign o_round_key = key_r;
  assign o_round_idx = idx_r;

`ifdef KEY_EXPANSION_ROUND_STORE_EN
  logic [NB_KEY-1:0] store_r [0:N_ROUNDS];

  // Round key store: cleared on reset and on every accepted start
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i <= N_ROUNDS; i++) begin
        store_r[i] <= {NB_KEY{1'b0}};
      end
    end else if (accept_s) begin
      for (int i = 0; i <= N_ROUNDS; i++) begin
        store_r[i] <= {NB_KEY{1'b0}};
      end
    end else if (transfer_s) begin
      store_r[idx_r] <= key_r;
    end
  end

  assign o_rd_key = (i_rd_idx <= LAST_IDX) ? store_r[i_rd_idx] : {NB_KEY{1'b0}};
`else
  logic unused_s;
  assign unused_s = accept_s;
`endif
endmodule

// File: tb/tb_key_expansion_round_gen.sv
`timescale 1ns/1ps
module tb_key_expansion_round_gen;
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY  = 128'h0;
  localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         rdy_in;
  logic         ready;
  logic [127:0] rkey;
  logic [3:0]   idx;
  logic         valid;
  logic         done;
`ifdef KEY_EXPANSION_ROUND_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_keys [0:10];
  logic [127:0] got_keys [0:10];

  always #5 clk = ~clk;

  key_expansion_round_gen dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_key       (key),
    .o_ready     (ready),
    .o_round_key (rkey),
    .o_round_idx (idx),
    .o_valid     (valid),
    .i_ready     (rdy_in),
    .o_done      (done)
`ifdef KEY_EXPANSION_ROUND_STORE_EN
    ,
    .i_rd_idx    (rd_idx),
    .o_rd_key    (rd_key)
`endif
  );

  // ---------------- reference model: FIPS-197 word expansion ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (a != 8'h00 && gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic build_schedule(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc   = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  // Called at a negedge while idle; leaves us at the negedge of cycle 1.
  task automatic start_key(input logic [127:0] k);
    start = 1'b1;
    key   = k;
    @(negedge clk);
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Consumes one full sequence; ends at the negedge of the o_done cycle.
  task automatic run_body(input string tag, input bit rand_rdy, input bit poke,
                          output int cyc_out);
    int got;
    int cyc;
    got = 0;
    cyc = 1;
    while (got < 11 && cyc < 400) begin
      checks++;
      if (valid !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s_ctl cyc=%0d valid=%b ready=%b done=%b required 1/0/0",
                 tag, cyc, valid, ready, done);
      end
      checks++;
      if (idx !== 4'(got) || rkey !== exp_keys[got]) begin
        errors++;
        $display("FAIL %s_key cyc=%0d idx=%0d key=%h required idx=%0d key=%h",
                 tag, cyc, idx, rkey, got, exp_keys[got]);
      end
      got_keys[got] = rkey;
      rdy_in = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        key   = OTHER_KEY;
      end
      @(posedge clk);
      if (rdy_in) got++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (got < 11) begin
      errors++;
      $display("FAIL %s_timeout transfers=%0d required 11", tag, got);
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_done done=%b valid=%b ready=%b required 1/0/1", tag, done, valid, ready);
    end
    cyc_out = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1;
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0 || rkey !== 128'h0 || idx !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%b valid=%b key=%h idx=%0d done=%b required 1/0/0/0/0",
               ready, valid, rkey, idx, done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset ready=%b valid=%b done=%b required 1/0/0", ready, valid, done);
    end
  endtask

  task automatic test_fips;
    int cyc;
    build_schedule(FIPS_KEY);
    start_key(FIPS_KEY);
    run_body("fips", 1'b0, 1'b0, cyc);
    checks++;
    if (cyc != 12) begin
      errors++;
      $display("FAIL fips_done_cycle cycle=%0d required 12", cyc);
    end
    checks++;
    if (got_keys[0] !== FIPS_KEY || got_keys[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
        got_keys[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL fips_vectors idx0=%h idx1=%h idx10=%h required FIPS-197 values",
               got_keys[0], got_keys[1], got_keys[10]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b required 0", done);
    end
  endtask

  task automatic test_store;
`ifdef KEY_EXPANSION_ROUND_STORE_EN
    int cyc;
    rd_idx = 4'd10; #1;
    checks++;
    if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL store_idx10 got=%h required d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key);
    end
    rd_idx = 4'd12; #1;
    checks++;
    if (rd_key !== 128'h0) begin
      errors++;
      $display("FAIL store_idx12 got=%h required 0", rd_key);
    end
    rd_idx = 4'd0; #1;
    checks++;
    if (rd_key !== FIPS_KEY) begin
      errors++;
      $display("FAIL store_idx0 got=%h required %h", rd_key, FIPS_KEY);
    end
    @(negedge clk);
    build_schedule(ZERO_KEY);
    start_key(ZERO_KEY);
    rd_idx = 4'd10; #1;
    checks++;
    if (rd_key !== 128'h0) begin
      errors++;
      $display("FAIL store_clear got=%h required 0", rd_key);
    end
    @(negedge clk);
    run_body("store_zero", 1'b0, 1'b0, cyc);
    @(negedge clk);
`endif
  endtask

  task automatic test_random_ready;
    int cyc;
    for (int rep = 0; rep < 3; rep++) begin
      build_schedule(FIPS_KEY);
      start_key(FIPS_KEY);
      run_body("rand_ready", 1'b1, 1'b0, cyc);
      @(negedge clk);
    end
  endtask

  task automatic test_idle_ready;
    rdy_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_ready valid=%b done=%b ready=%b required 0/0/1", valid, done, ready);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    build_schedule(FIPS_KEY);
    start_key(FIPS_KEY);
    run_body("poke_start", 1'b1, 1'b1, cyc);
    // Start on the o_done cycle itself
    build_schedule(ZERO_KEY);
    start_key(ZERO_KEY);
    run_body("b2b_zero", 1'b0, 1'b0, cyc);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    int cyc;
    build_schedule(FIPS_KEY);
    rdy_in = 1'b1;
    start_key(FIPS_KEY);
    n = 0;
    while (idx !== 4'd5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL reset_mid_wait idx=%0d required 5", idx);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || ready !== 1'b1 || rkey !== 128'h0 || idx !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid valid=%b ready=%b key=%h idx=%0d done=%b required 0/1/0/0/0",
               valid, ready, rkey, idx, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    build_schedule(ZERO_KEY);
    start_key(ZERO_KEY);
    run_body("zero_after_reset", 1'b0, 1'b0, cyc);
    checks++;
    if (got_keys[1] !== 128'h62636363626363636263636362636363 ||
        got_keys[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      errors++;
      $display("FAIL zero_vectors idx1=%h idx10=%h required 6263..63 / b4ef..188e",
               got_keys[1], got_keys[10]);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    key    = 128'h0;
    rdy_in = 1'b0;
`ifdef KEY_EXPANSION_ROUND_STORE_EN
    rd_idx = 4'd0;
`endif
    test_reset();
    test_fips();
    test_store();
    test_random_ready();
    test_idle_ready();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
